// File: rtl/lcd_cmd_seq_if.sv
// lcd_cmd_seq_if
// Link between the host-side command sequencer and the LCD image controller.
//   cmd[2:0]   command code, meaningful while cmd_valid is high
//   cmd_valid  one-cycle command strobe, driven by the sequencer
//   busy       controller cannot accept a command while high
//   done       controller has finished its write-back
//   IRB_RW     controller write strobe, active low
//   IRB_A/D    write-back address and data
// Handshake: the sequencer raises cmd_valid for a single cycle, and only when
// it has seen busy low on the previous edge. There is no ready/ack return:
// busy low at issue time is the acceptance. Back-to-back strobes never occur.
interface lcd_cmd_seq_if;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       busy;
   logic       done;
   logic       IRB_RW;
   logic [5:0] IRB_A;
   logic [7:0] IRB_D;

   modport master (output cmd, cmd_valid,
                   input  busy, done, IRB_RW, IRB_A, IRB_D);
   modport slave  (input  cmd, cmd_valid,
                   output busy, done, IRB_RW, IRB_A, IRB_D);
endinterface

// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq
// Runs a command program from a small ROM into the LCD image controller,
// appends a write-back command if the program lacks one, and captures the
// 64-byte write-back stream into a local frame buffer with a running checksum.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          one-cycle pulse, accepted in IDLE, FINISH or ERROR
//   prog_len       number of ROM entries to run (0 = write-back only)
//   cmd_rom_a/q    command ROM address out, data in (usable on the next edge)
//   bus            controller link (cmd/cmd_valid/busy/done/IRB_*)
//   rd_addr/data   combinational frame buffer read port
//   wr_count       captured writes since start, saturating at 64
//   checksum       sum of captured bytes modulo 2^16
//   seq_done       program complete and frame captured
//   seq_err        timeout in WAIT_RDY or WAIT_DONE
//   dbg_state      current FSM state, for checkers
module lcd_cmd_seq #(
   parameter int PROG_AW = 4,
   parameter int GAP_CYC = 1,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [PROG_AW:0]   prog_len,
   output logic [PROG_AW-1:0] cmd_rom_a,
   input  logic [2:0]         cmd_rom_q,
   lcd_cmd_seq_if.master      bus,
   input  logic [5:0]         rd_addr,
   output logic [7:0]         rd_data,
   output logic [6:0]         wr_count,
   output logic [15:0]        checksum,
   output logic               seq_done,
   output logic               seq_err,
   output logic [2:0]         dbg_state
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_WAIT_RDY, ST_ISSUE,
      ST_GAP, ST_WAIT_DONE, ST_FINISH, ST_ERROR
   } state_t;

   state_t             state_q, state_d;
   logic [PROG_AW:0]   len_q, len_d;
   logic [PROG_AW:0]   idx_q, idx_d;
   logic [PROG_AW-1:0] rom_a_q, rom_a_d;
   logic [2:0]         pend_q, pend_d;
   logic [2:0]         cmd_q, cmd_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic [6:0]         wr_count_q, wr_count_d;
   logic [15:0]        checksum_q, checksum_d;
   logic               mem_we;
   logic [7:0]         mem_q [64];

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      rom_a_d    = rom_a_q;
      pend_d     = pend_q;
      cmd_d      = cmd_q;
      tmo_d      = tmo_q;
      gap_d      = gap_q;
      wr_count_d = wr_count_q;
      checksum_d = checksum_q;
      mem_we     = 1'b0;

      // Capture runs in every state; a start acceptance below overrides it.
      if (!bus.IRB_RW) begin
         mem_we     = 1'b1;
         checksum_d = checksum_q + {8'd0, bus.IRB_D};
         if (wr_count_q != 7'd64) wr_count_d = wr_count_q + 7'd1;
      end

      case (state_q)
         ST_IDLE, ST_FINISH, ST_ERROR: begin
            if (start) begin
               len_d      = prog_len;
               rom_a_d    = '0;
               idx_d      = '0;
               wr_count_d = '0;
               checksum_d = '0;
               mem_we     = 1'b0;
               if (prog_len == '0) begin
                  pend_d  = 3'd0;
                  tmo_d   = '0;
                  state_d = ST_WAIT_RDY;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            pend_d  = cmd_rom_q;
            tmo_d   = '0;
            state_d = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            if (!bus.busy) begin
               cmd_d   = pend_q;   // loaded on entry so cmd is stable under cmd_valid
               state_d = ST_ISSUE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_ISSUE: begin
            if (pend_q == 3'd0) begin
               // Write-back issued (explicit or appended); ROM is not read again.
               tmo_d   = '0;
               state_d = ST_WAIT_DONE;
            end else begin
               idx_d   = idx_q + (PROG_AW+1)'(1);
               rom_a_d = rom_a_q + PROG_AW'(1);
               gap_d   = '0;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               if (idx_q < len_q) begin
                  state_d = ST_FETCH;
               end else begin
                  pend_d  = 3'd0;
                  tmo_d   = '0;
                  state_d = ST_WAIT_RDY;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (bus.done && wr_count_q == 7'd64) begin
               state_d = ST_FINISH;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         rom_a_q    <= '0;
         pend_q     <= '0;
         cmd_q      <= '0;
         tmo_q      <= '0;
         gap_q      <= '0;
         wr_count_q <= '0;
         checksum_q <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         rom_a_q    <= rom_a_d;
         pend_q     <= pend_d;
         cmd_q      <= cmd_d;
         tmo_q      <= tmo_d;
         gap_q      <= gap_d;
         wr_count_q <= wr_count_d;
         checksum_q <= checksum_d;
      end
   end

   // Frame buffer has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[bus.IRB_A] <= bus.IRB_D;
   end

   assign cmd_rom_a     = rom_a_q;
   assign bus.cmd       = cmd_q;
   assign bus.cmd_valid = (state_q == ST_ISSUE);
   assign rd_data       = mem_q[rd_addr];
   assign wr_count      = wr_count_q;
   assign checksum      = checksum_q;
   assign seq_done      = (state_q == ST_FINISH);
   assign seq_err       = (state_q == ST_ERROR);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
module tb_lcd_cmd_seq;
   localparam int PROG_AW = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic [PROG_AW:0]   prog_len;
   logic [PROG_AW-1:0] cmd_rom_a;
   logic [2:0]         cmd_rom_q;
   logic [5:0]         rd_addr;
   logic [7:0]         rd_data;
   logic [6:0]         wr_count;
   logic [15:0]        checksum;
   logic               seq_done;
   logic               seq_err;
   logic [2:0]         dbg_state;

   lcd_cmd_seq_if bus ();

   lcd_cmd_seq #(.PROG_AW(PROG_AW), .GAP_CYC(1), .TIMEOUT(255)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .prog_len  (prog_len),
      .cmd_rom_a (cmd_rom_a),
      .cmd_rom_q (cmd_rom_q),
      .bus       (bus),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_count  (wr_count),
      .checksum  (checksum),
      .seq_done  (seq_done),
      .seq_err   (seq_err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Command ROM: data follows the address within the cycle.
   logic [2:0] rom [16];
   assign cmd_rom_q = rom[cmd_rom_a];

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];
   logic [2:0] exp_head;
   int         vcount;
   bit         wb_seen;
   bit         prev_valid;
   int         busy_mode;      // 0 low, 1 random, 2 stuck high
   logic [7:0] frame_m [64];
   bit         written_m [64];
   int         sum_m;
   int         cnt_m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Controller-side busy behaviour.
   always @(negedge clk) begin
      case (busy_mode)
         0:       bus.busy = 1'b0;
         1:       bus.busy = ($urandom_range(0, 3) == 0);
         default: bus.busy = 1'b1;
      endcase
   end

   // Command monitor: every strobe is scored against the expected program.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.cmd_valid) begin
            check("valid_b2b", {31'd0, prev_valid}, 32'd0);
            vcount++;
            if (exp_q.size() == 0) begin
               check("extra_cmd", 32'd1, 32'd0);
            end else begin
               exp_head = exp_q.pop_front();
               check("cmd", {29'd0, bus.cmd}, {29'd0, exp_head});
            end
            if (bus.cmd == 3'd0) wb_seen = 1'b1;
         end
         prev_valid = bus.cmd_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_quiet(input string p);
      check({p, "_rom_a"},    {28'd0, cmd_rom_a},     32'd0);
      check({p, "_cmd"},      {29'd0, bus.cmd},       32'd0);
      check({p, "_valid"},    {31'd0, bus.cmd_valid}, 32'd0);
      check({p, "_wr_count"}, {25'd0, wr_count},      32'd0);
      check({p, "_checksum"}, {16'd0, checksum},      32'd0);
      check({p, "_done"},     {31'd0, seq_done},      32'd0);
      check({p, "_err"},      {31'd0, seq_err},       32'd0);
   endtask

   // Starts a program; the expected command list is the ROM prefix up to and
   // including the first 0 entry, with a 0 appended if none was reached.
   task automatic do_start(input int len, input bit stray);
      bit zero;
      @(negedge clk);
      prog_len = len[PROG_AW:0];
      start    = 1'b1;
      if (stray) begin
         bus.IRB_RW = 1'b0;
         bus.IRB_A  = 6'd0;
         bus.IRB_D  = 8'h55;
      end
      exp_q.delete();
      zero = 1'b0;
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(rom[i]);
         if (rom[i] == 3'd0) begin
            zero = 1'b1;
            break;
         end
      end
      if (!zero) exp_q.push_back(3'd0);
      vcount  = 0;
      wb_seen = 1'b0;
      sum_m   = 0;
      cnt_m   = 0;
      for (int i = 0; i < 64; i++) written_m[i] = 1'b0;
      @(negedge clk);
      start      = 1'b0;
      bus.IRB_RW = 1'b1;
   endtask

   task automatic write_byte(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.IRB_RW = 1'b0;
      bus.IRB_A  = a;
      bus.IRB_D  = d;
      frame_m[a]   = d;
      written_m[a] = 1'b1;
      sum_m = (sum_m + int'(d)) % 65536;
      if (cnt_m < 64) cnt_m++;
   endtask

   // mode 0 random bytes, 1 addr+1, 2 all 0xFF, 3 random addresses and extra writes
   task automatic run_frame(input int mode);
      int         n;
      logic [5:0] a;
      logic [7:0] d;
      for (int c = 0; c < 3000 && !wb_seen; c++) @(negedge clk);
      check("wb_issued", {31'd0, wb_seen}, 32'd1);
      n = (mode == 3) ? 64 + $urandom_range(0, 8) : 64;
      for (int i = 0; i < n; i++) begin
         a = (mode == 3) ? 6'($urandom_range(0, 63)) : 6'(i);
         case (mode)
            1:       d = 8'(i + 1);
            2:       d = 8'hFF;
            default: d = 8'($urandom_range(0, 255));
         endcase
         write_byte(a, d);
      end
      @(negedge clk);
      bus.IRB_RW = 1'b1;
      bus.done   = 1'b1;
      for (int c = 0; c < 20 && !seq_done; c++) @(negedge clk);
      bus.done = 1'b0;
      repeat (2) @(negedge clk);
      check("seq_done",  {31'd0, seq_done}, 32'd1);
      check("seq_err",   {31'd0, seq_err},  32'd0);
      check("wr_count",  {25'd0, wr_count}, cnt_m);
      check("checksum",  {16'd0, checksum}, sum_m);
      check("cmds_left", exp_q.size(),      32'd0);
      for (int k = 0; k < 4; k++) begin
         a = 6'($urandom_range(0, 63));
         for (int t = 0; t < 64 && !written_m[a]; t++) a = a + 6'd1;
         rd_addr = a;
         #1;
         check("rd_data", {24'd0, rd_data}, {24'd0, frame_m[a]});
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      prog_len   = '0;
      rd_addr    = '0;
      bus.done   = 1'b0;
      bus.IRB_RW = 1'b1;
      bus.IRB_A  = '0;
      bus.IRB_D  = '0;
      busy_mode  = 0;
      vcount     = 0;
      wb_seen    = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 3'd0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      reset = 1'b0;

      // Program ending in an explicit write-back.
      rom[0] = 3'd4; rom[1] = 3'd4; rom[2] = 3'd2; rom[3] = 3'd5; rom[4] = 3'd0;
      do_start(5, 1'b0);
      run_frame(0);
      check("a_wr_count", {25'd0, wr_count}, 32'd64);

      // No 0 entry: write-back gets appended; busy toggles randomly.
      rom[0] = 3'd6; rom[1] = 3'd7; rom[2] = 3'd1; rom[3] = 3'd3;
      busy_mode = 1;
      do_start(3, 1'b0);
      run_frame(0);

      // Write-back only; a write coinciding with start must be dropped.
      do_start(0, 1'b1);
      run_frame(1);
      check("c_checksum_2080", {16'd0, checksum}, 32'd2080);
      check("c_vcount", vcount, 32'd1);

      // Busy stuck high: timeout with no command issued.
      busy_mode = 2;
      @(negedge clk);
      rom[0] = 3'd3;
      do_start(4, 1'b0);
      repeat (300) @(negedge clk);
      check("d_seq_err",  {31'd0, seq_err},  32'd1);
      check("d_seq_done", {31'd0, seq_done}, 32'd0);
      check("d_vcount",   vcount,            32'd0);
      exp_q.delete();
      busy_mode = 0;
      @(negedge clk);

      // All-0xFF frame, started from ERROR.
      rom[0] = 3'd1; rom[1] = 3'd2;
      do_start(2, 1'b0);
      check("e_err_cleared", {31'd0, seq_err}, 32'd0);
      run_frame(2);
      check("e_checksum_3fc0", {16'd0, checksum}, 32'h3FC0);
      rd_addr = 6'd37;
      #1;
      check("e_rd37", {24'd0, rd_data}, 32'hFF);

      // Reset while in GAP after the first command, then rerun from entry 0.
      for (int i = 0; i < 5; i++) rom[i] = 3'($urandom_range(1, 7));
      do_start(5, 1'b0);
      for (int c = 0; c < 200 && vcount < 1; c++) @(negedge clk);
      check("f_first_cmd", vcount, 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_quiet("f_reset");
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("f_held_valid", {31'd0, bus.cmd_valid}, 32'd0);
      reset = 1'b0;
      do_start(5, 1'b0);
      run_frame(0);

      // Random programs.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 16; i++)
            rom[i] = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         busy_mode = $urandom_range(0, 1);
         do_start($urandom_range(0, 16), 1'b0);
         run_frame(3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
